mem_port_arbiter: RTL and testbench

- Shares one unified memory port between the instruction-fetch requester (I) and the load/store requester (D).
- Lets the core move from separate instruction/data memories to a single multi-cycle memory.
- Serialises requests, one outstanding transaction at a time, using round-robin arbitration.
- Routes responses back to the owner of the transaction and aborts stalled transactions with an error after a timeout.

---
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one multi-cycle memory port between fetch and load/store
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [2:0]            d_mem_op,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [2:0]            mem_op,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  logic [1:0]    state;
  logic          owner;
  logic          last_owner;
  logic [CW-1:0] cnt;
  logic          idle;
  logic          abort;
  logic          done;
  // grants only in IDLE; a conflict goes to whoever did not own the previous transaction (owner 1 = D)
  always_comb begin
    idle  = state == IDLE;
    i_gnt = idle & i_req & (~d_req | last_owner);
    d_gnt = idle & d_req & (~i_req | ~last_owner);
    abort = ~idle & (cnt == LAST) & ~(state == WAIT & mem_rvalid);
    done  = (state == WAIT & mem_rvalid) | abort;
  end
  // transaction sequencing, timeout counting and response routing
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_op     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_rvalid   <= 1'b0;
      i_rdata    <= '0;
      i_err      <= 1'b0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
    end else begin
      i_rvalid <= 1'b0;
      i_err    <= 1'b0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      if (idle) begin
        if (i_gnt | d_gnt) begin
          state      <= ISSUE;
          owner      <= d_gnt;
          last_owner <= d_gnt;
          cnt        <= '0;
          mem_req    <= 1'b1;
          mem_we     <= d_gnt & d_we;
          mem_op     <= d_gnt ? d_mem_op : 3'b010;
          mem_addr   <= d_gnt ? d_addr : i_addr;
          mem_wdata  <= d_gnt ? d_wdata : '0;
        end
      end else begin
        cnt <= cnt + 1'b1;
        if (done) begin
          state   <= IDLE;
          mem_req <= 1'b0;
          if (owner) begin
            d_rvalid <= 1'b1;
            d_err    <= abort;
            d_rdata  <= abort ? '0 : mem_rdata;
          end else begin
            i_rvalid <= 1'b1;
            i_err    <= abort;
            i_rdata  <= abort ? '0 : mem_rdata;
          end
        end else if (state == ISSUE && mem_ready) begin
          mem_req <= 1'b0;
          state   <= WAIT;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of the arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int TO = 16;
  logic        clk = 0;
  logic        rst = 1;
  logic        i_req = 0, d_req = 0, d_we = 0, mem_ready = 0, mem_rvalid = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [2:0]  d_mem_op = 0;
  logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, mem_req, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [2:0]  mem_op;
  int checks = 0, failures = 0;
  // model of the shared port: is a transaction open, who owns it, has memory taken it, how long it has run
  bit busy, own_d, acc, last_d, gi_fire, gd_fire;
  int age;
  bit e_mreq, e_we, e_irv, e_ierr, e_drv, e_derr;
  logic [2:0]  e_op;
  logic [31:0] e_addr, e_wd, e_ird, e_drd;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_mem_op(d_mem_op), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  function automatic bit want_i();
    return i_req && (!d_req || last_d);
  endfunction

  function automatic bit want_d();
    return d_req && (!i_req || !last_d);
  endfunction

  task automatic respond(input bit err, input logic [31:0] data);
    busy = 0;
    e_mreq = 0;
    if (own_d) begin e_drv = 1; e_derr = err; e_drd = data; end
    else begin e_irv = 1; e_ierr = err; e_ird = data; end
  endtask

  task automatic model_edge();
    bit gi, gd;
    gi_fire = 0;
    gd_fire = 0;
    if (rst) begin
      busy = 0; last_d = 1; e_mreq = 0; e_we = 0; e_op = 0; e_addr = 0; e_wd = 0;
      e_irv = 0; e_ierr = 0; e_ird = 0; e_drv = 0; e_derr = 0; e_drd = 0;
    end else begin
      e_irv = 0; e_ierr = 0; e_drv = 0; e_derr = 0;
      if (!busy) begin
        gi = want_i();
        gd = want_d();
        if (gi || gd) begin
          busy = 1; own_d = gd; last_d = gd; acc = 0; age = 0; e_mreq = 1;
          e_we = gd && d_we;
          e_op = gd ? d_mem_op : 3'b010;
          e_addr = gd ? d_addr : i_addr;
          e_wd = gd ? d_wdata : 32'h0;
          gi_fire = gi;
          gd_fire = gd;
        end
      end else begin
        age++;
        if (acc && mem_rvalid) respond(0, mem_rdata);
        else if (age == TO) respond(1, 32'h0);
        else if (!acc && mem_ready) begin acc = 1; e_mreq = 0; end
      end
    end
  endtask

  task automatic settle();
    #1;
    chk("i_gnt", i_gnt, !busy && want_i());
    chk("d_gnt", d_gnt, !busy && want_d());
    chk("mem_req", mem_req, e_mreq);
    chk("mem_we", mem_we, e_we);
    chk("mem_op", mem_op, e_op);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("i_rvalid", i_rvalid, e_irv);
    chk("i_err", i_err, e_ierr);
    chk("i_rdata", i_rdata, e_ird);
    chk("d_rvalid", d_rvalid, e_drv);
    chk("d_err", d_err, e_derr);
    chk("d_rdata", d_rdata, e_drd);
  endtask

  task automatic clk_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic timeout_run(input bit rv_last);
    d_req = 1; d_we = 0; d_mem_op = 3'b100; d_addr = 32'h3000;
    settle(); chk("to_gnt", d_gnt, 1); clk_edge(); d_req = 0;
    mem_ready = 1; settle(); clk_edge(); mem_ready = 0;
    for (int n = 1; n < 16; n++) begin
      mem_rvalid = rv_last && n == 15; mem_rdata = 32'hCAFE0001;
      settle(); chk("to_quiet", d_rvalid, 0); clk_edge();
    end
    mem_rvalid = !rv_last;
    settle();
    chk("to_rvalid", d_rvalid, 1);
    chk("to_err", d_err, !rv_last);
    chk("to_rdata", d_rdata, rv_last ? 32'hCAFE0001 : 32'h0);
    clk_edge();
    settle(); chk("to_late", d_rvalid, 0); clk_edge();
    mem_rvalid = 0;
  endtask

  initial begin
    repeat (2) clk_edge();
    rst = 0;
    settle();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rdata", d_rdata, 0);
    // single fetch
    i_req = 1; i_addr = 32'h100;
    settle(); chk("f_gnt", i_gnt, 1); clk_edge(); i_req = 0;
    mem_ready = 1; settle();
    chk("f_req", mem_req, 1); chk("f_addr", mem_addr, 32'h100); chk("f_op", mem_op, 3'b010); chk("f_we", mem_we, 0);
    clk_edge(); mem_ready = 0;
    mem_rvalid = 1; mem_rdata = 32'h00500093; settle(); clk_edge(); mem_rvalid = 0;
    settle();
    chk("f_rvalid", i_rvalid, 1); chk("f_rdata", i_rdata, 32'h00500093); chk("f_err", i_err, 0); chk("f_drvalid", d_rvalid, 0);
    clk_edge();
    // conflict right after reset: I, D, I, D
    rst = 1; settle(); clk_edge(); rst = 0;
    i_req = 1; d_req = 1; d_we = 0; d_mem_op = 3'b001; i_addr = 32'h40; d_addr = 32'h80;
    for (int k = 0; k < 4; k++) begin
      settle();
      if (k > 0) chk("c_resp", (k % 2) ? i_rvalid : d_rvalid, 1);
      chk("c_gnt", {i_gnt, d_gnt}, (k % 2) ? 2'b01 : 2'b10);
      clk_edge();
      mem_ready = 1; settle(); chk("c_op", mem_op, (k % 2) ? 3'b001 : 3'b010); clk_edge(); mem_ready = 0;
      mem_rvalid = 1; mem_rdata = 32'h11 * (k + 1); settle(); clk_edge(); mem_rvalid = 0;
    end
    i_req = 0; d_req = 0;
    settle(); chk("c_last", d_rvalid, 1); chk("c_last_rd", d_rdata, 32'h44); clk_edge();
    // store with delayed ready
    d_req = 1; d_we = 1; d_mem_op = 3'b010; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF;
    settle(); chk("s_gnt", d_gnt, 1); clk_edge(); d_req = 0; d_we = 0;
    for (int j = 0; j < 4; j++) begin
      settle();
      chk("s_req", mem_req, 1); chk("s_we", mem_we, 1); chk("s_addr", mem_addr, 32'h2004); chk("s_wd", mem_wdata, 32'hDEADBEEF);
      mem_ready = j == 3;
      clk_edge();
    end
    mem_ready = 0;
    settle(); chk("s_dropreq", mem_req, 0); mem_rvalid = 1; clk_edge(); mem_rvalid = 0;
    settle(); chk("s_rvalid", d_rvalid, 1); chk("s_err", d_err, 0); clk_edge();
    // timeout abort, then completion on the final counted cycle
    timeout_run(0);
    timeout_run(1);
    // back-to-back with zero-wait memory
    d_req = 1; d_we = 0; d_addr = 32'h500; mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h77;
    for (int k = 0; k < 9; k++) begin
      settle();
      chk("b_gnt", d_gnt, k % 3 == 0);
      chk("b_rvalid", d_rvalid, k % 3 == 0 && k > 0);
      clk_edge();
    end
    d_req = 0;
    settle(); chk("b_tail", d_rvalid, 1); clk_edge();
    mem_ready = 0; mem_rvalid = 0;
    // reset while waiting for memory
    d_req = 1; settle(); clk_edge(); d_req = 0;
    mem_ready = 1; settle(); clk_edge(); mem_ready = 0;
    rst = 1; settle(); clk_edge(); rst = 0;
    mem_rvalid = 1; mem_rdata = 32'h99;
    settle();
    chk("r_mem_req", mem_req, 0); chk("r_addr", mem_addr, 0); chk("r_op", mem_op, 0); chk("r_wd", mem_wdata, 0);
    chk("r_drv", d_rvalid, 0); chk("r_drd", d_rdata, 0); chk("r_ird", i_rdata, 0);
    clk_edge(); mem_rvalid = 0;
    settle(); chk("r_stale", d_rvalid | i_rvalid, 0); clk_edge();
    i_req = 1; d_req = 1;
    settle(); chk("r_conf", {i_gnt, d_gnt}, 2'b10); clk_edge();
    i_req = 0;
    // randomized traffic; requests stay held with stable fields until granted
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 299) == 0;
      if (!i_req && $urandom_range(0, 2) == 0) begin i_req = 1; i_addr = $urandom; end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = $urandom_range(0, 1); d_mem_op = 3'($urandom); d_addr = $urandom; d_wdata = $urandom;
      end
      mem_ready = $urandom_range(0, 1);
      mem_rvalid = $urandom_range(0, 3) == 0;
      mem_rdata = $urandom;
      settle();
      clk_edge();
      if (gi_fire) i_req = 0;
      if (gd_fire) d_req = 0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
